gate_sweep_checker: RTL and testbench

//  Self-checking stimulus stage that sits directly upstream of the 2-input logic-gate block.
//  On start, drives a/b through 00,01,10,11 and waits a settle window per vector.

---
 rtl/gate_sweep_checker.sv | 186 ++++++++++++++++++
 tb/tb_gate_sweep_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Stimulus and checking stage that sits directly upstream of a 2-input
//   logic-gate block. When start is accepted, it steps {a,b} through 00, 01,
//   10 and 11. Each vector is held for SETTLE_CYCLES clocks, and then the
//   gate block's eight outputs are compared against a built-in truth table.
//   The stage reports a per-vector fail mask, the number of failing vectors,
//   the mismatch bits of the first failing vector and an overall pass flag.
//
// Ports
//   clk              in   1  clock, all state on the rising edge
//   rst              in   1  synchronous active-high reset
//   start            in   1  begin a sweep (only honoured while idle)
//   a, b             out  1  registered stimulus to the gate block
//   dut_out          in   8  {buffer,not,and,nand,or,nor,xor,xnor}, MSB=buffer
//   busy             out  1  sweep in progress (through the done cycle)
//   done             out  1  one-cycle completion pulse
//   pass             out  1  no vector failed; held until the next start
//   fail_mask        out  4  bit {a,b} set when that vector mismatched
//   err_count        out  3  number of failing vectors, 0..4
//   first_fail_bits  out  8  dut_out ^ expected of the first failing vector

module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [7:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count,
    output logic [7:0] first_fail_bits
);

    // The counter only has to hold SETTLE_CYCLES-1 down to 0.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("gate_sweep_checker: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t         state, state_next;
    logic [1:0]     idx, idx_next;
    logic [CW-1:0]  settle_cnt, settle_cnt_next;
    logic           a_next, b_next, busy_next, done_next, pass_next;
    logic [3:0]     fail_mask_next;
    logic [2:0]     err_count_next;
    logic [7:0]     first_fail_bits_next;
    logic [7:0]     mism;

    // Golden truth table for the gate block, in dut_out bit order.
    function automatic logic [7:0] golden(input logic ga, input logic gb);
        golden = {ga, ~ga, ga & gb, ~(ga & gb), ga | gb, ~(ga | gb), ga ^ gb, ~(ga ^ gb)};
    endfunction

    // a/b are registered, so the golden value always matches the applied vector.
    assign mism = dut_out ^ golden(a, b);

    // State register, plus the registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            idx             <= 2'd0;
            settle_cnt      <= '0;
            a               <= 1'b0;
            b               <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_mask       <= 4'd0;
            err_count       <= 3'd0;
            first_fail_bits <= 8'd0;
        end else begin
            state           <= state_next;
            idx             <= idx_next;
            settle_cnt      <= settle_cnt_next;
            a               <= a_next;
            b               <= b_next;
            busy            <= busy_next;
            done            <= done_next;
            pass            <= pass_next;
            fail_mask       <= fail_mask_next;
            err_count       <= err_count_next;
            first_fail_bits <= first_fail_bits_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_SETTLE;
                else       state_next = ST_IDLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) state_next = ST_CHECK;
                else                  state_next = ST_SETTLE;
            end
            ST_CHECK: begin
                if (idx == 2'd3) state_next = ST_DONE;
                else             state_next = ST_SETTLE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output and datapath next values (registered in the state register block).
    always_comb begin
        idx_next             = idx;
        settle_cnt_next      = settle_cnt;
        a_next               = a;
        b_next               = b;
        busy_next            = busy;
        done_next            = 1'b0;
        pass_next            = pass;
        fail_mask_next       = fail_mask;
        err_count_next       = err_count;
        first_fail_bits_next = first_fail_bits;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    idx_next             = 2'd0;
                    a_next               = 1'b0;
                    b_next               = 1'b0;
                    settle_cnt_next      = SETTLE_LOAD;
                    fail_mask_next       = 4'd0;
                    err_count_next       = 3'd0;
                    first_fail_bits_next = 8'd0;
                    pass_next            = 1'b0;
                    busy_next            = 1'b1;
                end else begin
                    busy_next = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt != '0) settle_cnt_next = settle_cnt - 1'b1;
                else                  settle_cnt_next = settle_cnt;
            end
            ST_CHECK: begin
                if (mism != 8'd0) begin
                    fail_mask_next[idx] = 1'b1;
                    err_count_next      = err_count + 3'd1;
                    // err_count is the count before this vector, so zero means first failure.
                    if (err_count == 3'd0) first_fail_bits_next = mism;
                    else                   first_fail_bits_next = first_fail_bits;
                end else begin
                    fail_mask_next = fail_mask;
                end
                if (idx == 2'd3) begin
                    // pass includes the verdict of this last vector.
                    done_next = 1'b1;
                    pass_next = (fail_mask_next == 4'd0);
                end else begin
                    idx_next          = idx + 2'd1;
                    {a_next, b_next}  = idx + 2'd1;
                    settle_cnt_next   = SETTLE_LOAD;
                end
            end
            ST_DONE: begin
                busy_next = 1'b0;
                a_next    = 1'b0;
                b_next    = 1'b0;
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker. Two instances are used, one with
// SETTLE_CYCLES=2 and one with SETTLE_CYCLES=1. Each instance drives a
// behavioural gate block that can have a fault injected. Expected sweep
// results are pushed to a scoreboard queue when a sweep is started. They
// are popped and compared when done pulses.

module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, start1;
    logic       a0, b0, a1, b1;
    logic [7:0] dut_out0, dut_out1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [3:0] mask0, mask1;
    logic [2:0] err0, err1;
    logic [7:0] ffb0, ffb1;
    int         fault0, fault1;
    logic       sel;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] mask;
        logic [2:0] err;
        logic [7:0] ffb;
        logic       pass;
    } exp_t;
    exp_t sb[$];

    // Behavioural gate block. Fault 1 = and stuck at 0, fault 2 = xor/xnor swapped.
    function automatic logic [7:0] gate_block(input logic ga, input logic gb, input int fault);
        logic [7:0] g;
        g = {ga, ~ga, ga & gb, ~(ga & gb), ga | gb, ~(ga | gb), ga ^ gb, ~(ga ^ gb)};
        if (fault == 1) g[5] = 1'b0;
        if (fault == 2) g[1:0] = {g[0], g[1]};
        return g;
    endfunction

    assign dut_out0 = gate_block(a0, b0, fault0);
    assign dut_out1 = gate_block(a1, b1, fault1);

    gate_sweep_checker #(.SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .dut_out(dut_out0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0),
        .err_count(err0), .first_fail_bits(ffb0)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1),
        .err_count(err1), .first_fail_bits(ffb1)
    );

    // Observation mux so one set of tasks serves either instance.
    logic       m_a, m_b, m_busy, m_done, m_pass;
    logic [3:0] m_mask;
    logic [2:0] m_err;
    logic [7:0] m_ffb;
    assign m_a    = sel ? a1    : a0;
    assign m_b    = sel ? b1    : b0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_pass = sel ? pass1 : pass0;
    assign m_mask = sel ? mask1 : mask0;
    assign m_err  = sel ? err1  : err0;
    assign m_ffb  = sel ? ffb1  : ffb0;

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({m_a, m_b, m_busy, m_done, m_pass} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_ctrl inst%0d: got %b expected 00000", s, {m_a, m_b, m_busy, m_done, m_pass});
            end
            checks++;
            if ({m_mask, m_err, m_ffb} !== 15'd0) begin
                errors++;
                $display("FAIL reset_results inst%0d: got mask=%b err=%0d ffb=%h expected zeros", s, m_mask, m_err, m_ffb);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one full sweep on the selected instance. The task is entered at a negedge
    // and leaves at the negedge of the idle cycle after done. start may be
    // re-pulsed during cycles rp1/rp2 of the sweep.
    task automatic sweep(input string name, input logic [3:0] emask, input logic [2:0] eerr,
                         input logic [7:0] effb, input int rp1, input int rp2);
        int         sc;
        int         dc;
        exp_t       e;
        exp_t       got;
        logic [1:0] eab;
        sc = sel ? 1 : 2;
        dc = 4 * (sc + 1) + 1;
        e.mask = emask; e.err = eerr; e.ffb = effb; e.pass = (emask == 4'd0);
        sb.push_back(e);
        got = e;
        set_start(1'b1);
        for (int k = 1; k <= dc + 1; k++) begin
            @(negedge clk);
            set_start((k == rp1) || (k == rp2));
            if (k < dc)       eab = 2'((k - 1) / (sc + 1));
            else if (k == dc) eab = 2'd3;
            else              eab = 2'd0;
            checks++;
            if ({m_a, m_b} !== eab) begin
                errors++;
                $display("FAIL %s ab cycle %0d: got %b expected %b", name, k, {m_a, m_b}, eab);
            end
            checks++;
            if ({m_busy, m_done} !== {(k <= dc), (k == dc)}) begin
                errors++;
                $display("FAIL %s busy_done cycle %0d: got %b expected %b", name, k,
                         {m_busy, m_done}, {(k <= dc), (k == dc)});
            end
            if (k == 1) begin
                checks++;
                if ({m_pass, m_mask, m_err, m_ffb} !== 16'd0) begin
                    errors++;
                    $display("FAIL %s cleared_at_start: got pass=%b mask=%b err=%0d ffb=%h expected zeros",
                             name, m_pass, m_mask, m_err, m_ffb);
                end
            end
            if (k == dc) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s scoreboard: got empty queue expected one entry", name);
                end else begin
                    got = sb.pop_front();
                end
            end
            if (k >= dc) begin
                checks++;
                if ({m_pass, m_mask, m_err, m_ffb} !== {got.pass, got.mask, got.err, got.ffb}) begin
                    errors++;
                    $display("FAIL %s results cycle %0d: got pass=%b mask=%b err=%0d ffb=%h expected pass=%b mask=%b err=%0d ffb=%h",
                             name, k, m_pass, m_mask, m_err, m_ffb, got.pass, got.mask, got.err, got.ffb);
                end
            end
        end
    endtask

    task automatic test_clean();
        sel = 1'b0; fault0 = 0;
        sweep("clean", 4'b0000, 3'd0, 8'h00, 0, 0);
    endtask

    task automatic test_and_stuck();
        sel = 1'b0; fault0 = 1;
        sweep("and_stuck", 4'b1000, 3'd1, 8'h20, 0, 0);
    endtask

    task automatic test_xor_swap();
        sel = 1'b0; fault0 = 2;
        sweep("xor_swap", 4'b1111, 3'd4, 8'h03, 0, 0);
    endtask

    task automatic test_start_ignored();
        sel = 1'b0; fault0 = 0;
        sweep("start_ignored", 4'b0000, 3'd0, 8'h00, 3, 7);
    endtask

    task automatic test_reset_mid_sweep();
        sel = 1'b0; fault0 = 2;
        set_start(1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            set_start(1'b0);
        end
        // Cycle 7: SETTLE of vector 2, with vectors 0 and 1 already failed.
        checks++;
        if ({m_a, m_b, m_mask, m_err} !== {2'b10, 4'b0011, 3'd2}) begin
            errors++;
            $display("FAIL mid_sweep_state: got ab=%b mask=%b err=%0d expected ab=10 mask=0011 err=2",
                     {m_a, m_b}, m_mask, m_err);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({m_a, m_b, m_busy, m_done, m_pass, m_mask, m_err, m_ffb} !== 20'd0) begin
                errors++;
                $display("FAIL reset_mid_sweep +%0d: got ab=%b busy=%b done=%b pass=%b mask=%b err=%0d ffb=%h expected zeros",
                         k, {m_a, m_b}, m_busy, m_done, m_pass, m_mask, m_err, m_ffb);
            end
            @(negedge clk);
        end
        fault0 = 0;
        sweep("after_reset", 4'b0000, 3'd0, 8'h00, 0, 0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b1; fault1 = 2;
        sweep("b2b_first", 4'b1111, 3'd4, 8'h03, 0, 0);
        fault1 = 0;
        sweep("b2b_second", 4'b0000, 3'd0, 8'h00, 0, 0);
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        fault0 = 0; fault1 = 0; sel = 1'b0;
        test_reset();
        test_clean();
        test_and_stuck();
        test_xor_swap();
        test_start_ignored();
        test_reset_mid_sweep();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
